// File: rtl/traffic_ctrl.sv
// traffic_ctrl: four-way intersection signal controller.
//
// Sequences the NS and EW signal heads through
//   AR_NS -> NS_G -> NS_Y -> AR_EW -> EW_G -> EW_Y -> AR_NS ...
// Green length is demand-actuated between GREEN_MIN and GREEN_MAX cycles.
// Demand is the OR of live vehicle counts and latched pedestrian requests.
// test_mode_i forces every timing parameter to 1 so each state lasts one cycle.
//
// Ports:
//   clock_i, reset_n_i        clock, asynchronous active-low reset
//   vcount_*_i [2:0]          vehicles waiting per approach (not latched)
//   ped_button_ns_i/_ew_i     pedestrian request levels, latched until served
//   test_mode_i               compress all phase timing to 1 cycle
//   green/yellow/red_*_o      registered lamp drives, one lamp per direction
//   transition_count_o [15:0] number of state changes since reset (wraps)
//   state_dbg_o [2:0]         current FSM state, for debug and checkers
//
// There is no valid/ready handshake on this block: inputs are levels sampled
// on every rising edge of clock_i.
module traffic_ctrl #(
    parameter int unsigned GREEN_MIN   = 8,
    parameter int unsigned GREEN_MAX   = 32,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 2
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [2:0]  vcount_northbound_i,
    input  logic [2:0]  vcount_southbound_i,
    input  logic [2:0]  vcount_eastbound_i,
    input  logic [2:0]  vcount_westbound_i,
    input  logic        ped_button_ns_i,
    input  logic        ped_button_ew_i,
    input  logic        test_mode_i,
    output logic        green_northsouth_o,
    output logic        yellow_northsouth_o,
    output logic        red_northsouth_o,
    output logic        green_eastwest_o,
    output logic        yellow_eastwest_o,
    output logic        red_eastwest_o,
    output logic [15:0] transition_count_o,
    output logic [2:0]  state_dbg_o
);

    typedef enum logic [2:0] {
        AR_NS = 3'd0,
        NS_G  = 3'd1,
        NS_Y  = 3'd2,
        AR_EW = 3'd3,
        EW_G  = 3'd4,
        EW_Y  = 3'd5
    } state_e;

    localparam logic [15:0] GMIN_P = 16'(GREEN_MIN);
    localparam logic [15:0] GMAX_P = 16'(GREEN_MAX);
    localparam logic [15:0] YEL_P  = 16'(YELLOW_TIME);
    localparam logic [15:0] AR_P   = 16'(ALLRED_TIME);

    // Lamp vector order: {g_ns, y_ns, r_ns, g_ew, y_ew, r_ew}
    localparam logic [5:0] LAMPS_ALL_RED = 6'b001_001;

    state_e      state_q, state_d;
    logic [15:0] t_q, t_d;
    logic        ped_ns_q, ped_ns_d;
    logic        ped_ew_q, ped_ew_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  lamps_q, lamps_d;

    logic [15:0] gmin_eff, gmax_eff, yel_eff, ar_eff;
    logic        ns_veh, ew_veh, ns_dem, ew_dem;
    logic        changed;

    // Test mode acts combinationally, so a mid-phase toggle is compared
    // against the running timer on the very next evaluation.
    always_comb begin
        gmin_eff = test_mode_i ? 16'd1 : GMIN_P;
        gmax_eff = test_mode_i ? 16'd1 : GMAX_P;
        yel_eff  = test_mode_i ? 16'd1 : YEL_P;
        ar_eff   = test_mode_i ? 16'd1 : AR_P;
    end

    always_comb begin
        ns_veh = (vcount_northbound_i != 3'd0) || (vcount_southbound_i != 3'd0);
        ew_veh = (vcount_eastbound_i  != 3'd0) || (vcount_westbound_i  != 3'd0);
        ns_dem = ns_veh || ped_ns_q;
        ew_dem = ew_veh || ped_ew_q;
    end

    // Next-state, timer, latches and counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AR_NS: if (t_q >= ar_eff)  state_d = NS_G;
            // A green with no competing demand holds forever; live vehicles on
            // the green approach extend it up to the maximum.
            NS_G:  if ((t_q >= gmin_eff) && ew_dem && (!ns_veh || (t_q >= gmax_eff)))
                       state_d = NS_Y;
            NS_Y:  if (t_q >= yel_eff) state_d = AR_EW;
            AR_EW: if (t_q >= ar_eff)  state_d = EW_G;
            EW_G:  if ((t_q >= gmin_eff) && ns_dem && (!ew_veh || (t_q >= gmax_eff)))
                       state_d = EW_Y;
            EW_Y:  if (t_q >= yel_eff) state_d = AR_NS;
            default: state_d = AR_NS;
        endcase

        changed = (state_d != state_q);

        if (changed)               t_d = 16'd1;
        else if (t_q == 16'hFFFF)  t_d = t_q;
        else                       t_d = t_q + 16'd1;

        cnt_d = changed ? (cnt_q + 16'd1) : cnt_q;

        // Entering a green serves its request; the clear beats a press
        // arriving on the same edge.
        if (changed && (state_d == NS_G)) ped_ns_d = 1'b0;
        else                              ped_ns_d = ped_ns_q || ped_button_ns_i;
        if (changed && (state_d == EW_G)) ped_ew_d = 1'b0;
        else                              ped_ew_d = ped_ew_q || ped_button_ew_i;
    end

    // Lamps are decoded from the next state so they register on the same
    // edge as the state itself.
    always_comb begin
        lamps_d = LAMPS_ALL_RED;
        case (state_d)
            NS_G:    lamps_d = 6'b100_001;
            NS_Y:    lamps_d = 6'b010_001;
            EW_G:    lamps_d = 6'b001_100;
            EW_Y:    lamps_d = 6'b001_010;
            default: lamps_d = LAMPS_ALL_RED;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= AR_NS;
            t_q      <= 16'd1;
            ped_ns_q <= 1'b0;
            ped_ew_q <= 1'b0;
            cnt_q    <= 16'd0;
            lamps_q  <= LAMPS_ALL_RED;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            ped_ns_q <= ped_ns_d;
            ped_ew_q <= ped_ew_d;
            cnt_q    <= cnt_d;
            lamps_q  <= lamps_d;
        end
    end

    assign {green_northsouth_o, yellow_northsouth_o, red_northsouth_o,
            green_eastwest_o,   yellow_eastwest_o,   red_eastwest_o} = lamps_q;
    assign transition_count_o = cnt_q;
    assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
module tb_traffic_ctrl;

  localparam int GREEN_MIN   = 8;
  localparam int GREEN_MAX   = 32;
  localparam int YELLOW_TIME = 3;
  localparam int ALLRED_TIME = 2;

  // Lamp patterns {g_ns,y_ns,r_ns,g_ew,y_ew,r_ew}
  localparam logic [5:0] P_AR  = 6'b001001;
  localparam logic [5:0] P_NSG = 6'b100001;
  localparam logic [5:0] P_NSY = 6'b010001;
  localparam logic [5:0] P_EWG = 6'b001100;
  localparam logic [5:0] P_EWY = 6'b001010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  vn = 3'd0, vs = 3'd0, ve = 3'd0, vw = 3'd0;
  logic        ped_ns = 1'b0, ped_ew = 1'b0, tmode = 1'b0;
  logic        gns, yns, rns, gew, yew, rew;
  logic [15:0] cnt;
  logic [2:0]  dbg_state;
  logic [5:0]  lamps;
  assign lamps = {gns, yns, rns, gew, yew, rew};

  traffic_ctrl #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YELLOW_TIME(YELLOW_TIME), .ALLRED_TIME(ALLRED_TIME)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .vcount_northbound_i(vn), .vcount_southbound_i(vs),
    .vcount_eastbound_i(ve), .vcount_westbound_i(vw),
    .ped_button_ns_i(ped_ns), .ped_button_ew_i(ped_ew),
    .test_mode_i(tmode),
    .green_northsouth_o(gns), .yellow_northsouth_o(yns), .red_northsouth_o(rns),
    .green_eastwest_o(gew), .yellow_eastwest_o(yew), .red_eastwest_o(rew),
    .transition_count_o(cnt), .state_dbg_o(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Phase index walks 0..5 in the order the intersection cycles through:
  // all-red(NS next), NS green, NS yellow, all-red(EW next), EW green, EW yellow.
  logic [5:0] lamp_tbl [6] = '{P_AR, P_NSG, P_NSY, P_AR, P_EWG, P_EWY};
  int          m_phase = 0;
  int          m_t     = 1;
  bit          m_pns   = 1'b0;
  bit          m_pew   = 1'b0;
  logic [15:0] m_cnt   = 16'd0;

  function automatic bit phase_done(int ph, int t, bit nsv, bit ewv, bit nsd, bit ewd, bit tm);
    int gmin, gmax, yel, ar;
    gmin = tm ? 1 : GREEN_MIN;
    gmax = tm ? 1 : GREEN_MAX;
    yel  = tm ? 1 : YELLOW_TIME;
    ar   = tm ? 1 : ALLRED_TIME;
    case (ph)
      0, 3:    return t >= ar;
      2, 5:    return t >= yel;
      1:       return (t >= gmin) && ewd && (!nsv || t >= gmax);
      default: return (t >= gmin) && nsd && (!ewv || t >= gmax);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_t     <= 1;
      m_pns   <= 1'b0;
      m_pew   <= 1'b0;
      m_cnt   <= 16'd0;
    end else if (phase_done(m_phase, m_t, (vn != 0) || (vs != 0), (ve != 0) || (vw != 0),
                            (vn != 0) || (vs != 0) || m_pns, (ve != 0) || (vw != 0) || m_pew,
                            tmode)) begin
      m_phase <= (m_phase + 1) % 6;
      m_t     <= 1;
      m_cnt   <= m_cnt + 16'd1;
      // Leaving phase 0 enters NS green, leaving phase 3 enters EW green.
      m_pns   <= (m_phase == 0) ? 1'b0 : (m_pns | ped_ns);
      m_pew   <= (m_phase == 3) ? 1'b0 : (m_pew | ped_ew);
    end else begin
      m_t     <= (m_t < 65535) ? m_t + 1 : m_t;
      m_pns   <= m_pns | ped_ns;
      m_pew   <= m_pew | ped_ew;
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (lamps !== lamp_tbl[m_phase] || cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL model_cmp: lamps=%b cnt=0x%0h state=%0d expected lamps=%b cnt=0x%0h (t=%0t)",
                 lamps, cnt, dbg_state, lamp_tbl[m_phase], m_cnt, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input logic [5:0] pat, input string name);
    int k = 0;
    while (lamps !== pat && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(lamps), 32'(pat));
  endtask

  // Number of cycles the current lamp pattern persists from now on.
  task automatic cycles_until_change(output int n);
    logic [5:0] pat;
    pat = lamps;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lamps === pat && n < 200);
  endtask

  task automatic set_veh(input logic [2:0] n, input logic [2:0] s,
                         input logic [2:0] e, input logic [2:0] w);
    vn = n; vs = s; ve = e; vw = w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [15:0] c0;
    logic [5:0]  p0;
    int k;

    // Reset, all inputs idle.
    step(3);
    chk("reset_lamps", 32'(lamps), 32'(P_AR));
    chk("reset_count", 32'(cnt), 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    step(1);
    chk("allred_cycle1", 32'(lamps), 32'(P_AR));
    step(1);
    chk("ns_green_after_allred", 32'(lamps), 32'(P_NSG));
    chk("count_after_allred", 32'(cnt), 32'd1);
    step(100);
    chk("ns_green_idle_hold", 32'(lamps), 32'(P_NSG));
    chk("count_idle_hold", 32'(cnt), 32'd1);

    // EW vehicle arrives during a long idle NS green.
    set_veh(0, 0, 2, 0);
    step(1);
    chk("ns_yellow_next_cycle", 32'(lamps), 32'(P_NSY));
    chk("count_ns_yellow", 32'(cnt), 32'd2);
    cycles_until_change(n);
    chk("yellow_len", 32'(n), 32'd3);
    cycles_until_change(n);
    chk("allred_len", 32'(n), 32'd2);
    chk("ew_green_entry", 32'(lamps), 32'(P_EWG));
    chk("count_ew_green", 32'(cnt), 32'd4);

    // Competing vehicles on both axes: each green runs to the maximum.
    set_veh(5, 0, 0, 1);
    cycles_until_change(n);
    chk("ew_green_max", 32'(n), 32'(GREEN_MAX));
    wait_for(P_NSG, "reach_ns_green");
    cycles_until_change(n);
    chk("ns_green_max", 32'(n), 32'(GREEN_MAX));
    wait_for(P_EWG, "reach_ew_green");
    cycles_until_change(n);
    chk("ew_green_max2", 32'(n), 32'(GREEN_MAX));
    set_veh(0, 0, 0, 0);

    // One-cycle EW pedestrian pulse at NS green t=3.
    wait_for(P_NSG, "reach_ns_green_ped");
    step(2);
    ped_ew = 1'b1;
    step(1);
    ped_ew = 1'b0;
    cycles_until_change(n);
    chk("ped_green_remaining", 32'(n), 32'd5);
    chk("ped_ns_yellow", 32'(lamps), 32'(P_NSY));
    wait_for(P_EWG, "ped_ew_green");
    step(50);
    chk("ew_green_hold_after_ped", 32'(lamps), 32'(P_EWG));
    chk("count_after_ped", 32'(cnt), 32'd16);

    // Randomised traffic, buttons, test mode and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 9) == 0) vn = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 9) == 0) vs = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 9) == 0) ve = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 9) == 0) vw = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      ped_ns = ($urandom_range(0, 19) == 0);
      ped_ew = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) tmode = ~tmode;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    ped_ns = 1'b0;
    ped_ew = 1'b0;

    // Test mode with demand on both axes: a change every cycle.
    tmode = 1'b1;
    set_veh(1, 0, 1, 0);
    step(8);
    c0 = cnt;
    p0 = lamps;
    step(1);
    chk("tm_every_cycle", 32'(cnt), 32'(c0 + 16'd1));
    step(5);
    chk("tm_six_changes", 32'(cnt), 32'(c0 + 16'd6));
    chk("tm_cycle_repeats", 32'(lamps), 32'(p0));
    k = 0;
    while (cnt !== 16'hFFFF && k < 70000) begin
      step(1);
      k++;
    end
    chk("tm_reach_ffff", 32'(cnt), 32'h0000FFFF);
    step(1);
    chk("count_wrap", 32'(cnt), 32'd0);

    // Reset asserted between edges at EW yellow t=2.
    tmode = 1'b0;
    set_veh(1, 0, 0, 0);
    wait_for(P_EWY, "reach_ew_yellow");
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_lamps", 32'(lamps), 32'(P_AR));
    chk("async_reset_count", 32'(cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_veh(0, 0, 0, 0);
    step(1);
    chk("restart_allred", 32'(lamps), 32'(P_AR));
    step(1);
    chk("restart_ns_green", 32'(lamps), 32'(P_NSG));
    chk("restart_count", 32'(cnt), 32'd1);
    step(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Four-way intersection traffic-light controller that sequences the north-south (NS) and east-west (EW) signal heads. Green duration is demand-actuated: each direction's green is bounded by a minimum and a maximum. Demand comes from per-approach vehicle counts and latched pedestrian buttons. A test mode compresses all phase timing, and a 16-bit counter reports every phase change to the bench and debug logic.

## Interface
- GREEN_MIN, 8: minimum green length in cycles; must be ≥1.
- GREEN_MAX, 32: green length after which a competing demand forces a change; must be ≥ GREEN_MIN.
- YELLOW_TIME, 3: yellow length in cycles; must be ≥1.
- ALLRED_TIME, 2: all-red clearance length in cycles; must be ≥1.
- clock_i  in  1  system clock; all state changes on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- vcount_northbound_i, vcount_southbound_i  in  3 each  vehicles waiting on the NS approaches.
- vcount_eastbound_i, vcount_westbound_i  in  3 each  vehicles waiting on the EW approaches.
- ped_button_ns_i  in  1  pedestrian request for the NS phase; level, sampled each cycle.
- ped_button_ew_i  in  1  pedestrian request for the EW phase; level, sampled each cycle.
- test_mode_i  in  1  when 1, all four timing parameters are treated as 1.
- green_northsouth_o, yellow_northsouth_o, red_northsouth_o  out  1 each  NS lamp drives.
- green_eastwest_o, yellow_eastwest_o, red_eastwest_o  out  1 each  EW lamp drives.
- transition_count_o  out  16  number of phase changes since reset.

## Operation
- States and their lamps:
  - AR_NS: all-red, next phase is NS.
  - NS_G: NS green, EW red.
  - NS_Y: NS yellow, EW red.
  - AR_EW: all-red, next phase is EW.
  - EW_G: EW green, NS red.
  - EW_Y: EW yellow, NS red.
- Exactly one lamp per direction is on in every state. Lamp outputs are registered, decoded from the state register.
- Phase timer `t`: 16-bit. It is 1 in the first cycle of each state and increments each cycle, saturating at 0xFFFF.
- Pedestrian latches:
  - ped_ns_req is set while ped_button_ns_i=1 and cleared on entry to NS_G.
  - ped_ew_req behaves the same with ped_button_ew_i and EW_G.
- Demand signals:
  - ns_veh = (vcount_northbound_i != 0) | (vcount_southbound_i != 0); ew_veh is defined likewise.
  - ns_dem = ns_veh | ped_ns_req; ew_dem = ew_veh | ped_ew_req.
- Transitions (evaluated in the last cycle of a state; the new state takes effect on the next edge):
  - AR_NS → NS_G when t ≥ ALLRED_TIME.
  - NS_G → NS_Y when t ≥ GREEN_MIN and ew_dem and (!ns_veh or t ≥ GREEN_MAX). With no EW demand, NS_G holds indefinitely.
  - NS_Y → AR_EW when t ≥ YELLOW_TIME.
  - AR_EW → EW_G, EW_G → EW_Y and EW_Y → AR_NS follow the same rules with NS and EW swapped.
- transition_count_o increments by 1 on every state change. It wraps from 0xFFFF to 0x0000.
- test_mode_i is combinational on the effective parameters. Toggling it mid-phase takes effect the next cycle, compared against the current t.

## Timing
- Reset values (asynchronous, immediate while reset_n_i=0):
  - state=AR_NS, t=1, both ped latches 0, transition_count_o=0.
  - red_northsouth_o=1 and red_eastwest_o=1; all other lamps 0.
- First edge after reset release starts AR_NS cycle counting. NS_G lamps appear exactly ALLRED_TIME cycles after release.
- Lamp outputs and transition_count_o change on the same edge as the state. Output latency from a qualifying input to the new lamp state is 1 cycle.
- Button press in the same cycle as entry into its own green: the clear wins, the latch stays 0, and the request counts as served.
- A button held through the whole green re-sets the latch on the cycle after entry.
- Vehicle counts are not latched. A count dropping to 0 before GREEN_MIN removes that demand.
- Reset asserted mid-phase: all outputs return to reset values asynchronously. Latched pedestrian requests are discarded.

## Test plan
- Reset, all inputs 0 → both red for 2 cycles, then NS_G holds for 100 cycles with transition_count_o=1.
- From idle NS_G at t=20, set vcount_eastbound_i=2 → NS yellow next cycle, lasting 3 cycles. Then all-red for 2 cycles, then EW green; transition_count_o reaches 4.
- NS_G with vcount_northbound_i=5 and vcount_westbound_i=1 held constant → NS green lasts exactly 32 cycles before yellow. EW green then lasts 32 cycles while northbound demand persists.
- Pulse ped_button_ew_i for 1 cycle at NS_G t=3, no vehicles → NS yellow after t=8. EW_G is entered and the latch clears. Without further demand, EW_G holds.
- test_mode_i=1, vcount_northbound_i=1 and vcount_eastbound_i=1 held → state changes every cycle and the six-state cycle repeats. transition_count_o advances by 6 per 6 cycles; forcing the count to 0xFFFF shows wrap to 0.
- Assert reset_n_i at EW_Y t=2 between clock edges → lamps go to both red immediately and transition_count_o reads 0. After release, the sequence restarts with AR_NS.
